// File: rtl/corr_pkg.sv
// Shared definitions for the correlation sequencer: state encoding, frame width
// helper and the default timing values also used by the core wrapper.
package corr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_PRECHARGE  = 3'd2,
    ST_EVAL       = 3'd3,
    ST_CAPTURE    = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  localparam int DEF_SAMPLES     = 2;
  localparam int DEF_OSF         = 8;
  localparam int DEF_PRE_CYCLES  = 2;
  localparam int DEF_EVAL_CYCLES = 4;
  localparam int DEF_FRAMES      = 16;
  localparam int DEF_CNT_W       = 5;

  function automatic int frame_width(input int samples, input int osf);
    return samples * osf;
  endfunction

endpackage

// File: rtl/corr_sequencer_if.sv
// Control, frame handshake and core-facing buses of the correlation sequencer.
// The sequencer uses the slave modport; the controller/frame source uses master.
interface corr_sequencer_if #(
  parameter int W     = 16,
  parameter int CNT_W = 5
);
  logic             Start;
  logic             Abort;
  logic             FrameValid;
  logic             FrameReady;
  logic [W-1:0]     FrameIn1;
  logic [W-1:0]     FrameIn2;
  logic [W-1:0]     CoreData1;
  logic [W-1:0]     CoreData2;
  logic             CoreP;
  logic             CoreOut;
  logic [CNT_W-1:0] HitCount;
  logic             Busy;
  logic             Done;

  modport slave (
    input  Start, Abort, FrameValid, FrameIn1, FrameIn2, CoreOut,
    output FrameReady, CoreData1, CoreData2, CoreP, HitCount, Busy, Done
  );

  modport master (
    output Start, Abort, FrameValid, FrameIn1, FrameIn2, CoreOut,
    input  FrameReady, CoreData1, CoreData2, CoreP, HitCount, Busy, Done
  );
endinterface

// File: rtl/corr_phase_timer.sv
// Loadable down-counter timing the precharge and evaluate phases.
// expire_o is high while the count sits at zero, i.e. in the last cycle of a phase.
module corr_phase_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] value_o,
  output logic             expire_o
);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (value_q != '0) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o  = value_q;
  assign expire_o = (value_q == '0);

endmodule

// File: rtl/corr_sequencer.sv
// Frame sequencer for the oversampled correlation core: accepts frame pairs,
// runs precharge/evaluate phases and counts hits over a window of FRAMES frames.
// Optional macro CORR_SYNC_EN adds a 2-flop synchronizer on CoreOut.
module corr_sequencer
  import corr_pkg::*;
#(
  parameter int SAMPLES     = DEF_SAMPLES,
  parameter int OSF         = DEF_OSF,
  parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
  parameter int EVAL_CYCLES = DEF_EVAL_CYCLES,
  parameter int FRAMES      = DEF_FRAMES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  corr_sequencer_if.slave  bus
);

  localparam int W = frame_width(SAMPLES, OSF);

  logic core_bit;

`ifdef CORR_SYNC_EN
  // Two extra EVAL cycles let this frame's result reach the end of the synchronizer.
  localparam int EVAL_LEN = EVAL_CYCLES + 2;

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.CoreOut};
    end
  end

  assign core_bit = sync_q[1];
`else
  localparam int EVAL_LEN = EVAL_CYCLES;

  assign core_bit = bus.CoreOut;
`endif

  localparam int TMR_MAX = (PRE_CYCLES > EVAL_LEN) ? PRE_CYCLES : EVAL_LEN;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e           state_q, state_d;
  logic [W-1:0]     data1_q, data2_q;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic             accept;
  logic             ready;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic [TMR_W-1:0] tmr_value_unused;
  logic             tmr_expire;

  corr_phase_timer #(.WIDTH(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .value_o    (tmr_value_unused),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    hit_d        = hit_q;
    frame_d      = frame_q;
    accept       = 1'b0;
    ready        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          hit_d   = '0;
          frame_d = '0;
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        ready = 1'b1;
        if (bus.FrameValid) begin
          accept       = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(PRE_CYCLES - 1);
          state_d      = ST_PRECHARGE;
        end
      end
      ST_PRECHARGE: begin
        if (tmr_expire) begin
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(EVAL_LEN - 1);
          state_d      = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (tmr_expire) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (core_bit && (hit_q != '1)) begin
          hit_d = hit_q + 1'b1;
        end
        frame_d = frame_q + 1'b1;
        state_d = (frame_q == CNT_W'(FRAMES - 1)) ? ST_DONE : ST_WAIT_FRAME;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a frame offered in the same cycle.
    if (bus.Abort) begin
      state_d  = ST_IDLE;
      hit_d    = hit_q;
      frame_d  = frame_q;
      accept   = 1'b0;
      ready    = 1'b0;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hit_q   <= '0;
      frame_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      frame_q <= frame_d;
      if (accept) begin
        data1_q <= bus.FrameIn1;
        data2_q <= bus.FrameIn2;
      end
    end
  end

  assign bus.FrameReady = ready;
  assign bus.CoreData1  = data1_q;
  assign bus.CoreData2  = data2_q;
  assign bus.CoreP      = !((state_q == ST_EVAL) || (state_q == ST_CAPTURE));
  assign bus.HitCount   = hit_q;
  assign bus.Busy       = (state_q != ST_IDLE);
  assign bus.Done       = (state_q == ST_DONE);

endmodule

// File: doc/corr_sequencer.md
Name: corr_sequencer

Overview:
- Sequencer for the oversampled correlation core, which has a 2*OSF-stage SR-latch/delayed-AND chain, a precharge input P and a single-bit result.
- Accepts one frame pair at a time over a valid/ready handshake and drives the core's two data buses.
- Runs fixed precharge and evaluate phases, samples the core result, and counts correlation hits over a window of FRAMES frames.
- Sits between the oversampling front end and the correlation statistics logic.

Parameters:
- SAMPLES, 2, symbols per frame.
- OSF, 8, oversampling factor; frame width W = SAMPLES*OSF.
- PRE_CYCLES, 2, clock cycles with P=1 before each evaluation (>=1).
- EVAL_CYCLES, 4, clock cycles with P=0 for the latch chain to settle (>=1).
- FRAMES, 16, frames per correlation window (>=1).
- CNT_W, 5, HitCount width; must satisfy 2^CNT_W > FRAMES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  begin a window; honoured only in IDLE.
- Abort  in  1  terminate the window; return to IDLE.
- FrameValid  in  1  frame pair available.
- FrameReady  out  1  sequencer accepts a frame this cycle.
- FrameIn1  in  W  channel-1 oversampled frame.
- FrameIn2  in  W  channel-2 oversampled frame.
- CoreData1  out  W  registered frame to core DataIn1.
- CoreData2  out  W  registered frame to core DataIn2.
- CoreP  out  1  core precharge (1 = precharge).
- CoreOut  in  1  core DataOut.
- HitCount  out  CNT_W  hits in the current or last window.
- Busy  out  1  window in progress (state != IDLE).
- Done  out  1  one-cycle pulse when a window completes.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; CoreP=1; CoreData1/2=0; HitCount=0; FrameReady=0; Busy=0; Done=0.
  - Phase timer and frame counter are 0.
- States: IDLE, WAIT_FRAME, PRECHARGE, EVAL, CAPTURE, DONE.
- CoreP is 0 only in EVAL and CAPTURE; it is 1 in every other state.
- IDLE:
  - Start=1 clears HitCount and the frame counter, then goes to WAIT_FRAME.
  - Start in any other state is ignored.
- WAIT_FRAME:
  - FrameReady=1.
  - On FrameValid&FrameReady: register FrameIn1/2 into CoreData1/2, load timer with PRE_CYCLES-1, go to PRECHARGE.
  - CoreData1/2 hold their value until the next accepted frame.
- PRECHARGE: lasts exactly PRE_CYCLES cycles, then loads timer with EVAL_CYCLES-1 and goes to EVAL.
- EVAL: lasts exactly EVAL_CYCLES cycles, then goes to CAPTURE.
- CAPTURE (1 cycle):
  - If CoreOut=1, HitCount increments, saturating at 2^CNT_W-1.
  - Frame counter increments.
  - If the counter reaches FRAMES, go to DONE; else go to WAIT_FRAME.
- DONE: Done=1 for this single cycle, then go to IDLE. HitCount holds until the next Start.
- Frame period with back-to-back FrameValid: 1+PRE_CYCLES+EVAL_CYCLES+1 cycles (8 at defaults).
- Abort (sampled every cycle, priority over all transitions):
  - Next state is IDLE, CoreP=1.
  - HitCount keeps its partial value; Done is not pulsed.
  - A frame offered in the same cycle is not accepted (FrameReady forced 0).
- Abort and Start together in IDLE: Abort wins; stay in IDLE.
- FRAMES=1: one frame, then DONE.
- FrameValid held low: the sequencer waits in WAIT_FRAME indefinitely with CoreP=1.
- Reset mid-window: immediate return to reset values; no Done pulse.

Optional Feature:
- Macro CORR_SYNC_EN.
- Defined:
  - CoreOut passes through a 2-flop synchronizer reset to 0.
  - EVAL lasts EVAL_CYCLES+2 cycles so CAPTURE samples the synchronized value of this frame.
  - Frame period grows by 2.
- Undefined: CoreOut is sampled directly in CAPTURE; no extra latency.

Decomposition:
- Package corr_pkg holds:
  - state encoding constants (IDLE..DONE);
  - the frame-width function W = SAMPLES*OSF;
  - default PRE_CYCLES, EVAL_CYCLES and FRAMES values shared with the core wrapper.
- One sub-module, corr_phase_timer:
  - loadable down-counter with load, value and expire outputs;
  - reused for both the PRECHARGE and EVAL phases.

Test Plan:
- Defaults, Start at cycle 0, FrameValid always 1, CoreOut=1 in every CAPTURE:
  - first accept at cycle 1; CoreP=0 on cycles 4-8;
  - Done at cycle 129; HitCount=16.
- CoreOut=1 on frames 0, 5 and 15 only -> HitCount=3 at Done; HitCount still 3 after 10 idle cycles.
- FrameValid held low for 20 cycles after Start:
  - FrameReady=1 and CoreP=1 throughout;
  - no PRECHARGE entry until FrameValid rises;
  - CoreData1/2 unchanged.
- Abort asserted during EVAL of frame 3 with 2 hits so far:
  - next cycle state=IDLE, CoreP=1, Busy=0, HitCount=2, no Done.
  - A subsequent Start clears HitCount to 0.
- rst_n pulsed low for 1 cycle during PRECHARGE:
  - all outputs at reset values asynchronously;
  - Start afterwards runs a full 16-frame window correctly.
- CORR_SYNC_EN defined:
  - the CoreP=0 window per frame is 7 cycles (EVAL_CYCLES+2 plus CAPTURE);
  - frame period is 10;
  - all-ones CoreOut gives HitCount=16 with Done at cycle 161.
